// File: rtl/dw_reg_array.sv
// Pixel window between the buffer-interface controller and the depthwise PE:
// a POY x KSIZE register array fed from the input buffer, from rotation within
// a row, or from per-row reuse FIFOs that carry pixels down to the next output row.

// Reuse FIFO: holds pixels rotated out of row r+1 for later reuse by row r.
// Latency: a word pushed on one edge can be popped on the next; the popped word sits in o_q from then on.
// Backpressure: none; a push into a full FIFO or a pop from an empty one is dropped and reported as a one-cycle event.
module dw_reuse_fifo #(
  parameter int DW     = 8,
  parameter int FDEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_dat,
  input  logic          i_pop,
  output logic [DW-1:0] o_q,
  output logic          o_ovf_evt,
  output logic          o_udf_evt
);
  localparam int AW = $clog2(FDEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FDEPTH);

  logic [DW-1:0] r_mem [FDEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_q;
  logic          w_full;
  logic          w_empty;
  logic          w_do_pop;
  logic          w_do_push;

  assign w_full    = (r_count == CNT_FULL);
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !w_empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_ovf_evt = i_push && w_full && !w_do_pop;
  assign o_udf_evt = i_pop && w_empty;
  assign o_q       = r_q;

  // Storage write; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Pointer, occupancy and output-word bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_q      <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_q      <= r_mem[r_rd_ptr];
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// Depthwise window register array with per-row shift commands and reuse FIFOs.
// Latency: commands show on win_pix one edge after sampling; win_vld is dwpe_ena delayed one cycle.
// Backpressure: none; the controller owns sequencing, FIFO misuse sets sticky fifo_ovf / fifo_udf.
module dw_reg_array #(
  parameter int POY    = 3,
  parameter int KSIZE  = 3,
  parameter int DW     = 8,
  parameter int FDEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*POY-1:0]          reg_array_cmd,
  input  logic [POY*DW-1:0]         buf_pix,
  input  logic                      fifo_read,
  input  logic                      dwpe_ena,
  output logic [POY*KSIZE*DW-1:0]   win_pix,
  output logic                      win_vld,
  output logic                      fifo_ovf,
  output logic                      fifo_udf
);
  localparam logic [1:0] CMD_IB = 2'b00;
  localparam logic [1:0] CMD_SF = 2'b01;
  localparam logic [1:0] CMD_IF = 2'b10;

  logic [DW-1:0]  r_pix [POY][KSIZE];
  logic [DW-1:0]  w_fifo_q [POY];
  logic [DW-1:0]  w_shin [POY];
  logic [POY-1:0] w_shen;
  logic [POY-2:0] w_push;
  logic [POY-2:0] w_ovf_evt;
  logic [POY-2:0] w_udf_evt;
  logic           r_win_vld;
  logic           r_fifo_ovf;
  logic           r_fifo_udf;

  // The bottom row has no reuse FIFO; its IF command degrades to a hold.
  assign w_fifo_q[POY-1] = '0;

  genvar gr, gk;
  generate
    for (gr = 0; gr < POY-1; gr++) begin : g_fifo
      // Row r+1 rotating pushes its outgoing (pre-update) last pixel for row r.
      assign w_push[gr] = !rst && (reg_array_cmd[2*(gr+1) +: 2] == CMD_SF);

      dw_reuse_fifo #(
        .DW     (DW),
        .FDEPTH (FDEPTH)
      ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push[gr]),
        .i_push_dat (r_pix[gr+1][KSIZE-1]),
        .i_pop      (fifo_read && !rst),
        .o_q        (w_fifo_q[gr]),
        .o_ovf_evt  (w_ovf_evt[gr]),
        .o_udf_evt  (w_udf_evt[gr])
      );
    end

    for (gr = 0; gr < POY; gr++) begin : g_win_row
      for (gk = 0; gk < KSIZE; gk++) begin : g_win_col
        assign win_pix[DW*(gr*KSIZE+gk) +: DW] = r_pix[gr][gk];
      end
    end
  endgenerate

  // Decode each row command into a shift enable and the pixel entering column 0.
  always_comb begin
    for (int r = 0; r < POY; r++) begin
      w_shen[r] = 1'b0;
      w_shin[r] = '0;
      case (reg_array_cmd[2*r +: 2])
        CMD_IB: begin
          w_shen[r] = 1'b1;
          w_shin[r] = buf_pix[DW*r +: DW];
        end
        CMD_SF: begin
          w_shen[r] = 1'b1;
          w_shin[r] = r_pix[r][KSIZE-1];
        end
        CMD_IF: begin
          if (r < POY-1) begin
            w_shen[r] = 1'b1;
            w_shin[r] = w_fifo_q[r];
          end
        end
        default: ;
      endcase
    end
  end

  // Shift each enabled row one column towards KSIZE-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < POY; r++)
        for (int k = 0; k < KSIZE; k++)
          r_pix[r][k] <= '0;
    end else begin
      for (int r = 0; r < POY; r++) begin
        if (w_shen[r]) begin
          r_pix[r][0] <= w_shin[r];
          for (int k = 1; k < KSIZE; k++)
            r_pix[r][k] <= r_pix[r][k-1];
        end
      end
    end
  end

  // Window valid tracks the consume enable; error flags stick until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_vld  <= 1'b0;
      r_fifo_ovf <= 1'b0;
      r_fifo_udf <= 1'b0;
    end else begin
      r_win_vld <= dwpe_ena;
      if (|w_ovf_evt) r_fifo_ovf <= 1'b1;
      if (|w_udf_evt) r_fifo_udf <= 1'b1;
    end
  end

  assign win_vld  = r_win_vld;
  assign fifo_ovf = r_fifo_ovf;
  assign fifo_udf = r_fifo_udf;
endmodule

// File: tb/tb_dw_reg_array.sv
// Directed bench for dw_reg_array (POY=3, KSIZE=3, DW=8, FDEPTH=16):
// fill, rotate, reuse, FIFO overflow/underflow, valid timing and mid-run reset.
module tb_dw_reg_array;
  localparam logic [1:0] IB = 2'b00;
  localparam logic [1:0] SF = 2'b01;
  localparam logic [1:0] IF = 2'b10;
  localparam logic [1:0] NE = 2'b11;

  logic        clk;
  logic        rst;
  logic [5:0]  reg_array_cmd;
  logic [23:0] buf_pix;
  logic        fifo_read;
  logic        dwpe_ena;
  logic [71:0] win_pix;
  logic        win_vld;
  logic        fifo_ovf;
  logic        fifo_udf;

  int n_cmp;
  int n_bad;

  dw_reg_array #(
    .POY    (3),
    .KSIZE  (3),
    .DW     (8),
    .FDEPTH (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .reg_array_cmd (reg_array_cmd),
    .buf_pix       (buf_pix),
    .fifo_read     (fifo_read),
    .dwpe_ena      (dwpe_ena),
    .win_pix       (win_pix),
    .win_vld       (win_vld),
    .fifo_ovf      (fifo_ovf),
    .fifo_udf      (fifo_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // Reset with aggressive inputs that must be ignored.
    rst           = 1'b1;
    reg_array_cmd = {IB, IB, IB};
    buf_pix       = 24'hCC_BB_AA;
    fifo_read     = 1'b1;
    dwpe_ena      = 1'b1;
    tick();
    tick();
    chk("rst_pix", win_pix, 72'h0);
    chk("rst_vld", win_vld, 1'b0);
    chk("rst_ovf", fifo_ovf, 1'b0);
    chk("rst_udf", fifo_udf, 1'b0);

    rst           = 1'b0;
    reg_array_cmd = {NE, NE, NE};
    fifo_read     = 1'b0;
    dwpe_ena      = 1'b0;
    tick();
    chk("post_rst_pix", win_pix, 72'h0);
    chk("post_rst_vld", win_vld, 1'b0);
    chk("post_rst_flags", {fifo_ovf, fifo_udf}, 2'b00);

    // IB fill: row r gets 0x10*r + c for c = 1..3.
    for (int c = 1; c <= 3; c++) begin
      reg_array_cmd = {IB, IB, IB};
      buf_pix       = {8'h20 + 8'(c), 8'h10 + 8'(c), 8'(c)};
      tick();
    end
    chk("fill", win_pix, 72'h21_22_23_11_12_13_01_02_03);

    // Rotate all rows once; rows 1 and 2 push 0x11 / 0x21.
    reg_array_cmd = {SF, SF, SF};
    tick();
    chk("rotate", win_pix, 72'h22_23_21_12_13_11_02_03_01);

    // Pop into fifo_q while the window holds.
    reg_array_cmd = {NE, NE, NE};
    fifo_read     = 1'b1;
    tick();
    fifo_read = 1'b0;
    chk("hold", win_pix, 72'h22_23_21_12_13_11_02_03_01);
    chk("pop_flags", {fifo_ovf, fifo_udf}, 2'b00);

    // Reuse: rows 0..1 from FIFO, row 2 from buffer.
    reg_array_cmd = {IB, IF, IF};
    buf_pix       = 24'h99_00_00;
    tick();
    chk("reuse", win_pix, 72'h23_21_99_13_11_21_03_01_11);

    // FIFOs drained: one more pop underflows and leaves fifo_q alone.
    reg_array_cmd = {NE, NE, NE};
    fifo_read     = 1'b1;
    tick();
    fifo_read = 1'b0;
    chk("empty_pop_udf", fifo_udf, 1'b1);
    chk("empty_pop_ovf", fifo_ovf, 1'b0);

    // IF everywhere: rows 0..1 re-take the held fifo_q, row 2 holds.
    reg_array_cmd = {IF, IF, IF};
    tick();
    chk("q_held_bottom_if", win_pix, 72'h23_21_99_11_21_21_01_11_11);

    // Mid-run reset clears everything.
    rst           = 1'b1;
    reg_array_cmd = {NE, NE, NE};
    tick();
    rst = 1'b0;
    chk("rst2_pix", win_pix, 72'h0);
    chk("rst2_flags", {fifo_ovf, fifo_udf}, 2'b00);

    // Refill, then 17 pushes into each FIFO with no pop.
    for (int c = 1; c <= 3; c++) begin
      reg_array_cmd = {IB, IB, IB};
      buf_pix       = {8'h20 + 8'(c), 8'h10 + 8'(c), 8'(c)};
      tick();
    end
    for (int i = 0; i < 15; i++) begin
      reg_array_cmd = {SF, SF, NE};
      tick();
    end
    // Break the rotation period so word 16 differs from word 1.
    reg_array_cmd = {NE, IB, NE};
    buf_pix       = 24'h00_77_00;
    tick();
    reg_array_cmd = {SF, SF, NE};
    tick();
    chk("ovf_at_16", fifo_ovf, 1'b0);
    tick();
    chk("ovf_at_17", fifo_ovf, 1'b1);
    chk("udf_before_pop", fifo_udf, 1'b0);

    // 17 pops; row 0 consumes the stream via IF one cycle behind.
    reg_array_cmd = {NE, NE, NE};
    fifo_read     = 1'b1;
    tick();
    for (int j = 2; j <= 17; j++) begin
      reg_array_cmd = {NE, NE, IF};
      tick();
      if (j == 4)  chk("stream_head", win_pix[23:0], 24'h11_12_13);
      if (j == 16) chk("udf_at_16", fifo_udf, 1'b0);
    end
    chk("udf_at_17", fifo_udf, 1'b1);
    fifo_read     = 1'b0;
    reg_array_cmd = {NE, NE, IF};
    tick();
    chk("stream_tail", win_pix[23:0], 24'h13_12_12);

    // Valid pipeline: two-cycle pulse delayed by one.
    reg_array_cmd = {NE, NE, NE};
    tick();
    chk("vld_idle", win_vld, 1'b0);
    dwpe_ena = 1'b1;
    #1;
    chk("vld_not_early", win_vld, 1'b0);
    tick();
    chk("vld_1", win_vld, 1'b1);
    tick();
    chk("vld_2", win_vld, 1'b1);
    dwpe_ena = 1'b0;
    tick();
    chk("vld_off", win_vld, 1'b0);

    // Reset in the middle of a valid pulse.
    dwpe_ena = 1'b1;
    tick();
    chk("vld_pre_rst", win_vld, 1'b1);
    rst = 1'b1;
    tick();
    chk("vld_rst", win_vld, 1'b0);
    chk("flags_rst", {fifo_ovf, fifo_udf}, 2'b00);
    chk("pix_rst", win_pix, 72'h0);
    rst      = 1'b0;
    dwpe_ena = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
